// File: rtl/tx_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tx_request_arbiter                                               |
// | Purpose : Round-robin sharing of the Aurora TX serializer among NUM_REQ    |
// |           requesters; optional SEND watchdog under `TX_WATCHDOG_EN.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tx_request_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int SEND_DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*SEND_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_dst_addr,
    input  logic [NUM_REQ*2-1:0]            req_ttl,
    input  logic [NUM_REQ*2-1:0]            req_router_id,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic                            req_drop,
    output logic                            ser_send_valid,
    output logic [SEND_DATA_WIDTH-1:0]      ser_data,
    output logic [ADDR_WIDTH-1:0]           ser_dst_addr,
    output logic [1:0]                      ser_ttl,
    output logic [1:0]                      ser_router_id,
    input  logic                            ser_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            timeout_err
);

    localparam int                 c_GW       = $clog2(NUM_REQ);
    localparam logic [c_GW-1:0]    c_LAST     = c_GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SEND    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_GW-1:0]     r_rr_ptr;

    logic [NUM_REQ-1:0]  w_mask;
    logic [NUM_REQ-1:0]  w_hi;
    logic [NUM_REQ-1:0]  w_pick;
    logic [c_GW-1:0]     w_winner;
    logic [c_GW-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]  w_ack_vec;

`ifdef TX_WATCHDOG_EN
    localparam int              c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    logic [c_WD_W-1:0]          r_wd_cnt;
`endif

    // Requests at or above the pointer take priority; otherwise wrap to the lowest set bit.
    always_comb begin
        w_mask   = ~((c_ONE << r_rr_ptr) - c_ONE);
        w_hi     = req_valid & w_mask;
        w_pick   = (|w_hi) ? w_hi : req_valid;
        w_winner = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_pick[j]) begin
                w_winner = c_GW'(j);
            end
        end
        w_next_ptr = (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
        w_ack_vec  = c_ONE << grant_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            req_ack        <= '0;
            req_drop       <= 1'b0;
            ser_send_valid <= 1'b0;
            ser_data       <= '0;
            ser_dst_addr   <= '0;
            ser_ttl        <= '0;
            ser_router_id  <= '0;
            busy           <= 1'b0;
            grant_id       <= '0;
            timeout_err    <= 1'b0;
`ifdef TX_WATCHDOG_EN
            r_wd_cnt       <= '0;
`endif
        end else begin
            req_ack     <= '0;
            req_drop    <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        ser_data      <= req_data[w_winner*SEND_DATA_WIDTH +: SEND_DATA_WIDTH];
                        ser_dst_addr  <= req_dst_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                        ser_ttl       <= req_ttl[w_winner*2 +: 2];
                        ser_router_id <= req_router_id[w_winner*2 +: 2];
                        grant_id      <= w_winner;
                        r_rr_ptr      <= w_next_ptr;
                        busy          <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ser_ttl == 2'd0) begin
                        req_ack  <= w_ack_vec;
                        req_drop <= 1'b1;
                        r_state  <= S_RELEASE;
                    end else begin
                        ser_send_valid <= 1'b1;
                        r_state        <= S_SEND;
`ifdef TX_WATCHDOG_EN
                        r_wd_cnt       <= '0;
`endif
                    end
                end
                S_SEND: begin
                    if (ser_done) begin
                        ser_send_valid <= 1'b0;
                        req_ack        <= w_ack_vec;
                        r_state        <= S_RELEASE;
`ifdef TX_WATCHDOG_EN
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        ser_send_valid <= 1'b0;
                        req_ack        <= w_ack_vec;
                        timeout_err    <= 1'b1;
                        r_state        <= S_RELEASE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_request_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_tx_request_arbiter                                            |
// | Purpose : Randomized transaction-level check of tx_request_arbiter.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tx_request_arbiter;

    localparam int NUM_REQ = 3;
    localparam int SDW     = 1024;
    localparam int AW      = 10;
    localparam int TO      = 8;
    localparam int GW      = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*SDW-1:0]  req_data = '0;
    logic [NUM_REQ*AW-1:0]   req_dst_addr = '0;
    logic [NUM_REQ*2-1:0]    req_ttl = '0;
    logic [NUM_REQ*2-1:0]    req_router_id = '0;
    logic [NUM_REQ-1:0]      req_ack;
    logic                    req_drop;
    logic                    ser_send_valid;
    logic [SDW-1:0]          ser_data;
    logic [AW-1:0]           ser_dst_addr;
    logic [1:0]              ser_ttl;
    logic [1:0]              ser_router_id;
    logic                    ser_done = 1'b0;
    logic                    busy;
    logic [GW-1:0]           grant_id;
    logic                    timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference state: round-robin pointer and the payload each requester presents.
    int         m_rr = 0;
    logic [SDW-1:0] m_data [NUM_REQ];
    logic [AW-1:0]  m_addr [NUM_REQ];
    logic [1:0]     m_ttl  [NUM_REQ];
    logic [1:0]     m_rid  [NUM_REQ];

    always #5 clk = ~clk;

    tx_request_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .SEND_DATA_WIDTH (SDW),
        .ADDR_WIDTH      (AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_dst_addr   (req_dst_addr),
        .req_ttl        (req_ttl),
        .req_router_id  (req_router_id),
        .req_ack        (req_ack),
        .req_drop       (req_drop),
        .ser_send_valid (ser_send_valid),
        .ser_data       (ser_data),
        .ser_dst_addr   (ser_dst_addr),
        .ser_ttl        (ser_ttl),
        .ser_router_id  (ser_router_id),
        .ser_done       (ser_done),
        .busy           (busy),
        .grant_id       (grant_id),
        .timeout_err    (timeout_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic repack;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data[r*SDW +: SDW]       = m_data[r];
            req_dst_addr[r*AW +: AW]     = m_addr[r];
            req_ttl[r*2 +: 2]            = m_ttl[r];
            req_router_id[r*2 +: 2]      = m_rid[r];
        end
    endtask

    // force_ttl < 0 gives a random TTL per requester.
    task automatic new_payloads(input int force_ttl);
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int w = 0; w < SDW / 32; w++) begin
                m_data[r][w*32 +: 32] = $urandom();
            end
            m_addr[r] = AW'($urandom());
            m_ttl[r]  = (force_ttl < 0) ? 2'($urandom()) : 2'(force_ttl);
            m_rid[r]  = 2'($urandom());
        end
        repack();
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(m_rr + i) % NUM_REQ]) return (m_rr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // One arbitration round starting from IDLE: grant, load, send/drop, release.
    // ser_done is raised so that the d-th SEND edge samples it.
    task automatic run_txn(input logic [NUM_REQ-1:0] v, input int d, input bit drop_mid,
                           output int winner);
        int                 w;
        int                 hi;
        int                 exp_hi;
        bit                 timed_out;
        logic [NUM_REQ-1:0] exp_ack;
        w         = model_pick(v);
        winner    = w;
        timed_out = 1'b0;
        req_valid = v;
        ser_done  = 1'b0;
        step();
        if (w < 0) begin
            checks++;
            if (busy !== 1'b0 || req_ack !== '0) begin
                errors++;
                $display("FAIL idle_no_req: busy=%0b ack=%b, expected busy=0 ack=000", busy, req_ack);
            end
            return;
        end
        m_rr    = (w + 1) % NUM_REQ;
        exp_ack = NUM_REQ'(1) << w;
        checks++;
        if (grant_id !== GW'(w) || busy !== 1'b1 || ser_send_valid !== 1'b0) begin
            errors++;
            $display("FAIL grant: grant_id=%0d busy=%0b send_valid=%0b, expected grant_id=%0d busy=1 send_valid=0",
                     grant_id, busy, ser_send_valid, w);
        end
        checks++;
        if (ser_data !== m_data[w] || ser_dst_addr !== m_addr[w] || ser_ttl !== m_ttl[w] ||
            ser_router_id !== m_rid[w]) begin
            errors++;
            $display("FAIL latch: data[31:0]=%h addr=%h ttl=%0d rid=%0d, expected data[31:0]=%h addr=%h ttl=%0d rid=%0d",
                     ser_data[31:0], ser_dst_addr, ser_ttl, ser_router_id,
                     m_data[w][31:0], m_addr[w], m_ttl[w], m_rid[w]);
        end
        ser_done = 1'($urandom());
        step();
        ser_done = 1'b0;
        if (m_ttl[w] == 2'd0) begin
            checks++;
            if (req_ack !== exp_ack || req_drop !== 1'b1 || ser_send_valid !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL ttl_drop: ack=%b drop=%0b send_valid=%0b tmo=%0b, expected ack=%b drop=1 send_valid=0 tmo=0",
                         req_ack, req_drop, ser_send_valid, timeout_err, exp_ack);
            end
        end else begin
            checks++;
            if (ser_send_valid !== 1'b1 || req_ack !== '0 || req_drop !== 1'b0) begin
                errors++;
                $display("FAIL load: send_valid=%0b ack=%b drop=%0b, expected send_valid=1 ack=000 drop=0",
                         ser_send_valid, req_ack, req_drop);
            end
            hi = (ser_send_valid === 1'b1) ? 1 : 0;
            for (int k = 1; k <= d; k++) begin
                ser_done = (k == d);
                if (drop_mid && k == 1) req_valid[w] = 1'b0;
                step();
                if (k == d) begin
                    checks++;
                    if (req_ack !== exp_ack || ser_send_valid !== 1'b0 || timeout_err !== 1'b0 || req_drop !== 1'b0) begin
                        errors++;
                        $display("FAIL done_ack: ack=%b send_valid=%0b tmo=%0b drop=%0b, expected ack=%b send_valid=0 tmo=0 drop=0",
                                 req_ack, ser_send_valid, timeout_err, req_drop, exp_ack);
                    end
                    break;
                end
`ifdef TX_WATCHDOG_EN
                if (k == TO) begin
                    timed_out = 1'b1;
                    checks++;
                    if (req_ack !== exp_ack || timeout_err !== 1'b1 || ser_send_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout: ack=%b tmo=%0b send_valid=%0b, expected ack=%b tmo=1 send_valid=0",
                                 req_ack, timeout_err, ser_send_valid, exp_ack);
                    end
                    break;
                end
`endif
                checks++;
                if (ser_send_valid !== 1'b1 || req_ack !== '0 || ser_data !== m_data[w]) begin
                    errors++;
                    $display("FAIL send_hold: send_valid=%0b ack=%b, expected send_valid=1 ack=000 with stable data",
                             ser_send_valid, req_ack);
                end
                if (ser_send_valid === 1'b1) hi++;
            end
            ser_done = 1'b0;
            exp_hi   = timed_out ? TO : d;
            checks++;
            if (hi !== exp_hi) begin
                errors++;
                $display("FAIL valid_len: send_valid high %0d cycles, expected %0d", hi, exp_hi);
            end
        end
        req_valid[w] = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || req_ack !== '0 || req_drop !== 1'b0 || timeout_err !== 1'b0 || ser_send_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: busy=%0b ack=%b drop=%0b tmo=%0b send_valid=%0b, expected all 0",
                     busy, req_ack, req_drop, timeout_err, ser_send_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (req_ack !== '0 || req_drop !== 1'b0 || ser_send_valid !== 1'b0 || ser_data !== '0 ||
            ser_dst_addr !== '0 || ser_ttl !== '0 || ser_router_id !== '0 || busy !== 1'b0 ||
            grant_id !== '0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ack=%b drop=%0b sv=%0b busy=%0b grant=%0d tmo=%0b, expected all 0",
                     req_ack, req_drop, ser_send_valid, busy, grant_id, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
    endtask

    task automatic test_single;
        int w;
        new_payloads(2);
        run_txn(3'b001, 18, 1'b0, w);
    endtask

    task automatic test_rotation;
        int w;
        new_payloads(1);
        for (int i = 0; i < 4; i++) begin
            run_txn(3'b111, $urandom_range(1, 5), 1'b0, w);
        end
    endtask

    task automatic test_rr_wrap;
        int w;
        new_payloads(3);
        run_txn(3'b010, 2, 1'b0, w);
        run_txn(3'b011, 3, 1'b0, w);
        run_txn(3'b011, 1, 1'b0, w);
    endtask

    task automatic test_ttl_drop;
        int w;
        new_payloads(1);
        m_ttl[1] = 2'd0;
        repack();
        run_txn(3'b010, 5, 1'b0, w);
    endtask

    task automatic test_drop_valid_mid;
        int w;
        new_payloads(2);
        run_txn(3'b001, 6, 1'b1, w);
    endtask

    task automatic test_done_outside_send;
        req_valid = '0;
        ser_done  = 1'b1;
        step();
        step();
        ser_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ack !== '0 || ser_send_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: busy=%0b ack=%b send_valid=%0b, expected 0 000 0", busy, req_ack, ser_send_valid);
        end
    endtask

    task automatic test_long_wait;
        int w;
        new_payloads(3);
        run_txn(3'b100, 30, 1'b0, w);
    endtask

    task automatic test_random;
        int w;
        for (int i = 0; i < 40; i++) begin
            new_payloads(-1);
            run_txn(NUM_REQ'($urandom()), $urandom_range(1, 12), 1'($urandom()), w);
        end
    endtask

    task automatic test_reset_mid_send;
        int w;
        new_payloads(2);
        req_valid = 3'b010;
        step();
        step();
        step();
        m_rr = 2;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ser_send_valid !== 1'b0 || req_ack !== '0 || grant_id !== '0 ||
            ser_data !== '0 || ser_ttl !== '0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_send: busy=%0b sv=%0b ack=%b grant=%0d ttl=%0d, expected all 0",
                     busy, ser_send_valid, req_ack, grant_id, ser_ttl);
        end
        req_valid = '0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
        run_txn(3'b101, 2, 1'b0, w);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_rr_wrap();
        test_ttl_drop();
        test_drop_valid_mid();
        test_done_outside_send();
        test_long_wait();
        test_random();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
